data_mem_ctrl: RTL and testbench

Parametrised data memory for the MIPS datapath, replacing the fixed 4 KB memory. It supports byte, halfword and word accesses at any naturally aligned byte offset, with sign- or zero-extended loads. Accesses use a valid/ready request and response handshake with a one-cycle registered response. Two memory-mapped output registers (seven-segment and LED) are reset and mirrored to pins. A saturating error counter tracks rejected accesses.

---
 rtl/data_mem_ctrl.sv | 172 +++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Parametrised byte-addressable data memory with valid/ready request/response handshake,
// two memory-mapped output registers and a saturating rejected-access counter.
module data_mem_ctrl #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned ERR_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [31:0]      req_addr,
    input  logic [1:0]       req_size,
    input  logic             req_signed,
    input  logic [31:0]      wtData,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic             rsp_err,
    output logic [ERR_W-1:0] err_cnt,
    output logic [31:0]      seg7,
    output logic [31:0]      led_data
);
    localparam int unsigned       DEPTH    = 2 ** ADDR_W;
    localparam int unsigned       HI_LSB   = ADDR_W + 2;
    localparam logic [ADDR_W-1:0] SEG7_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] LED_IDX  = ADDR_W'(DEPTH - 2);

    logic [31:0]      mem_q [DEPTH];
    logic             rsp_valid_q, rsp_valid_d;
    logic [31:0]      rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [31:0]      seg7_q, seg7_d;
    logic [31:0]      led_q, led_d;

    logic              accept;
    logic [ADDR_W-1:0] idx;
    logic [1:0]        off;
    logic              acc_err;
    logic              is_mmio;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic [31:0]       rd_word;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [31:0]       load_val;

    function automatic logic [31:0] merge_be(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  en);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = en[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        end
        return res;
    endfunction

    assign req_ready = !rsp_valid_q || rsp_ready;
    assign accept    = ce && req_valid && req_ready;
    assign idx       = req_addr[ADDR_W+1:2];
    assign off       = req_addr[1:0];
    assign is_mmio   = (idx == SEG7_IDX) || (idx == LED_IDX);

    // Alignment/range check, lane enables and lane-replicated store data
    always_comb begin
        acc_err = 1'b0;
        be      = 4'b0000;
        wdata   = wtData;
        case (req_size)
            2'b00: begin
                be    = 4'b0001 << off;
                wdata = {4{wtData[7:0]}};
            end
            2'b01: begin
                be      = 4'b0011 << off;
                wdata   = {2{wtData[15:0]}};
                acc_err = off[0];
            end
            2'b10: begin
                be      = 4'b1111;
                acc_err = (off != 2'b00);
            end
            default: acc_err = 1'b1;
        endcase
        if ((req_addr >> HI_LSB) != 32'd0) begin
            acc_err = 1'b1;
        end
    end

    // Load path; MMIO words shadow the array
    always_comb begin
        if (idx == SEG7_IDX) begin
            rd_word = seg7_q;
        end else if (idx == LED_IDX) begin
            rd_word = led_q;
        end else begin
            rd_word = mem_q[idx];
        end
        rd_byte = rd_word[{off, 3'b000} +: 8];
        rd_half = rd_word[{off[1], 4'b0000} +: 16];
        case (req_size)
            2'b00:   load_val = req_signed ? {{24{rd_byte[7]}}, rd_byte} : {24'd0, rd_byte};
            2'b01:   load_val = req_signed ? {{16{rd_half[15]}}, rd_half} : {16'd0, rd_half};
            default: load_val = rd_word;
        endcase
    end

    // Array storage is intentionally not reset
    always_ff @(posedge clk) begin
        if (accept && req_we && !acc_err && !is_mmio) begin
            mem_q[idx] <= merge_be(mem_q[idx], wdata, be);
        end
    end

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        err_cnt_d   = err_cnt_q;
        seg7_d      = seg7_q;
        led_d       = led_q;
        if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = acc_err;
            rsp_data_d  = 32'd0;
            if (acc_err) begin
                if (err_cnt_q != '1) begin
                    err_cnt_d = err_cnt_q + ERR_W'(1);
                end
            end else if (req_we) begin
                if (idx == SEG7_IDX) begin
                    seg7_d = merge_be(seg7_q, wdata, be);
                end else if (idx == LED_IDX) begin
                    led_d = merge_be(led_q, wdata, be);
                end
            end else begin
                rsp_data_d = load_val;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'd0;
            rsp_err_q   <= 1'b0;
            err_cnt_q   <= '0;
            seg7_q      <= 32'd0;
            led_q       <= 32'd0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            err_cnt_q   <= err_cnt_d;
            seg7_q      <= seg7_d;
            led_q       <= led_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign err_cnt   = err_cnt_q;
    assign seg7      = seg7_q;
    assign led_data  = led_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: byte-array reference model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic.
module tb_data_mem_ctrl;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned ERR_W  = 8;
    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam int unsigned BYTES  = 4 * DEPTH;
    localparam int          CMAX   = (2 ** ERR_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             ce;
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [31:0]      req_addr;
    logic [1:0]       req_size;
    logic             req_signed;
    logic [31:0]      wtData;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_data;
    logic             rsp_err;
    logic [ERR_W-1:0] err_cnt;
    logic [31:0]      seg7;
    logic [31:0]      led_data;

    int checks = 0;
    int errors = 0;

    // Reference model: flat byte space; the top 8 bytes are the MMIO registers
    logic [7:0]  mb [BYTES];
    bit          kn [BYTES];
    bit          m_valid;
    logic [31:0] m_data;
    bit          m_err;
    bit          m_dknown;
    int          m_cnt;

    data_mem_ctrl #(.ADDR_W(ADDR_W), .ERR_W(ERR_W)) dut (
        .clk(clk), .rst(rst), .ce(ce), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
        .wtData(wtData), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .err_cnt(err_cnt), .seg7(seg7), .led_data(led_data)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input int unsigned a);
        return {mb[a+3], mb[a+2], mb[a+1], mb[a]};
    endfunction

    function automatic bit is_err(input logic [31:0] a, input logic [1:0] s);
        if (s == 2'd3) return 1'b1;
        if (s == 2'd1 && a[0]) return 1'b1;
        if (s == 2'd2 && a[1:0] != 2'd0) return 1'b1;
        return a >= BYTES;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = 32'd0;
        m_err   = 1'b0;
        m_cnt   = 0;
        for (int i = 0; i < int'(BYTES); i++) begin
            kn[i] = (i >= int'(BYTES) - 8);
            if (kn[i]) mb[i] = 8'h00;
        end
    endtask

    task automatic check_outputs();
        chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
        if (m_valid) begin
            chk("rsp_err", 32'(rsp_err), 32'(m_err));
            if (m_dknown) chk("rsp_data", rsp_data, m_data);
        end
        chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
        chk("seg7", seg7, word_at(BYTES - 4));
        chk("led_data", led_data, word_at(BYTES - 8));
    endtask

    // One clock cycle: inputs already driven after a negedge; ends on the next negedge
    task automatic step();
        bit          acc;
        int          n;
        logic [31:0] ld;
        #1;
        chk("req_ready", 32'(req_ready), 32'(!m_valid || rsp_ready));
        acc = ce && req_valid && (!m_valid || rsp_ready);
        @(posedge clk);
        if (m_valid && rsp_ready) m_valid = 1'b0;
        if (acc) begin
            m_valid  = 1'b1;
            m_err    = is_err(req_addr, req_size);
            m_data   = 32'd0;
            m_dknown = 1'b1;
            n        = 1 << req_size;
            if (m_err) begin
                if (m_cnt < CMAX) m_cnt++;
            end else if (req_we) begin
                for (int i = 0; i < n; i++) begin
                    mb[req_addr + 32'(i)] = wtData[8*i +: 8];
                    kn[req_addr + 32'(i)] = 1'b1;
                end
            end else begin
                ld = 32'd0;
                for (int i = 0; i < n; i++) begin
                    ld[8*i +: 8] = mb[req_addr + 32'(i)];
                    if (!kn[req_addr + 32'(i)]) m_dknown = 1'b0;
                end
                if (req_signed && ld[8*n-1]) begin
                    for (int i = n; i < 4; i++) ld[8*i +: 8] = 8'hFF;
                end
                m_data = ld;
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic req(input bit we, input logic [31:0] a, input logic [1:0] s,
                       input bit sg, input logic [31:0] d);
        ce = 1'b1; req_valid = 1'b1; req_we = we; req_addr = a;
        req_size = s; req_signed = sg; wtData = d;
        step();
    endtask

    task automatic init_region();
        for (int w = 0; w < 16; w++) req(1'b1, 32'(4 * w), 2'd2, 1'b0, 32'd0);
        req_valid = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1; ce = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0;
        req_size = 2'd0; req_signed = 1'b0; wtData = 32'd0; rsp_ready = 1'b1;
        model_reset();
        #2;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_seg7", seg7, 32'd0);
        chk("rst_led", led_data, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        init_region();

        // Word store/load
        req(1'b1, 32'h10, 2'd2, 1'b0, 32'h89ABCDEF);
        chk("st_word_err", 32'(rsp_err), 32'd0);
        req(1'b0, 32'h10, 2'd2, 1'b0, 32'd0);
        chk("ld_word_valid", 32'(rsp_valid), 32'd1);
        chk("ld_word", rsp_data, 32'h89ABCDEF);

        // Byte store then signed/unsigned loads
        req(1'b1, 32'h10, 2'd2, 1'b0, 32'd0);
        req(1'b1, 32'h11, 2'd0, 1'b0, 32'h80);
        req(1'b0, 32'h11, 2'd0, 1'b1, 32'd0);
        chk("ld_sbyte", rsp_data, 32'hFFFFFF80);
        req(1'b0, 32'h10, 2'd1, 1'b0, 32'd0);
        chk("ld_uhalf", rsp_data, 32'h00008000);
        req(1'b0, 32'h10, 2'd2, 1'b0, 32'd0);
        chk("ld_word2", rsp_data, 32'h00008000);

        // Rejected accesses
        req(1'b1, 32'h13, 2'd1, 1'b0, 32'hFFFF);
        chk("mis_err", 32'(rsp_err), 32'd1);
        chk("mis_data", rsp_data, 32'd0);
        chk("mis_cnt", 32'(err_cnt), 32'd1);
        req(1'b0, 32'h10, 2'd2, 1'b0, 32'd0);
        chk("mis_nowrite", rsp_data, 32'h00008000);
        req(1'b0, 32'(BYTES), 2'd2, 1'b0, 32'd0);
        chk("oor_cnt", 32'(err_cnt), 32'd2);

        // MMIO stores
        req(1'b1, 32'(BYTES - 4), 2'd2, 1'b0, 32'h12345678);
        chk("seg7_wr", seg7, 32'h12345678);
        req(1'b1, 32'(BYTES - 8 + 2), 2'd0, 1'b0, 32'hAA);
        chk("led_wr", led_data, 32'h00AA0000);
        req(1'b0, 32'(BYTES - 4), 2'd1, 1'b0, 32'd0);
        chk("seg7_rd", rsp_data, 32'h00005678);

        // Backpressure then release
        req(1'b0, 32'h10, 2'd2, 1'b0, 32'd0);
        rsp_ready = 1'b0;
        req_addr = 32'h0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_ready", 32'(req_ready), 32'd0);
            chk("bp_data", rsp_data, 32'h00008000);
        end
        rsp_ready = 1'b1;
        step();
        chk("rel_data0", rsp_data, 32'd0);
        req(1'b0, 32'h10, 2'd2, 1'b0, 32'd0);
        chk("rel_valid", 32'(rsp_valid), 32'd1);
        chk("rel_data1", rsp_data, 32'h00008000);

        // Chip enable low
        ce = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10;
        req_size = 2'd2; wtData = 32'hDEADBEEF;
        step();
        chk("ce0_valid", 32'(rsp_valid), 32'd0);
        req(1'b0, 32'h10, 2'd2, 1'b0, 32'd0);
        chk("ce0_nowrite", rsp_data, 32'h00008000);
        chk("ce0_cnt", 32'(err_cnt), 32'd2);

        // Saturation
        for (int i = 0; i < CMAX + 1 + 5; i++) req(1'b0, 32'h0, 2'd3, 1'b0, 32'd0);
        chk("sat_cnt", 32'(err_cnt), 32'(CMAX));

        // Asynchronous reset mid-cycle
        req_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_seg7", seg7, 32'd0);
        chk("arst_led", led_data, 32'd0);
        chk("arst_cnt", 32'(err_cnt), 32'd0);
        chk("arst_valid", 32'(rsp_valid), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        init_region();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            int unsigned r;
            ce         = ($urandom_range(0, 9) != 0);
            req_valid  = ($urandom_range(0, 4) != 0);
            rsp_ready  = ($urandom_range(0, 3) != 0);
            req_we     = $urandom_range(0, 1) == 1;
            req_signed = $urandom_range(0, 1) == 1;
            wtData     = $urandom;
            req_size   = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            r = $urandom_range(0, 9);
            if (r <= 5)      req_addr = 32'($urandom_range(0, 63));
            else if (r <= 7) req_addr = 32'(BYTES - 8 + $urandom_range(0, 7));
            else if (r == 8) req_addr = 32'(BYTES + $urandom_range(0, 255));
            else             req_addr = $urandom;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
